// File: rtl/forwarding_hazard_unit_pkg.sv
// Shared processor definitions: register-specifier width, forward-select
// encodings used by the EX-stage operand muxes, and the hazard tracking record.
package forwarding_hazard_unit_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  // Forward-select encodings for the EX operand muxes; 2'b11 is never driven.
  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_WB    = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  // One in-flight instruction as seen by the hazard unit.
  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic                  mem_read;
    logic [REG_ADDR_W-1:0] dest;
  } track_entry_t;

  // True when the entry will produce the value the consumer reads from src.
  // Register 0 is hard-wired, so it never counts as produced.
  function automatic logic produces(track_entry_t e, logic [REG_ADDR_W-1:0] src,
                                    logic uses);
    return e.valid && e.reg_write && (e.dest != '0) && (e.dest == src) && uses;
  endfunction

endpackage

// File: rtl/forwarding_hazard_unit_track_stage.sv
// Single tracking-pipe entry: a resettable register that can load a bubble.
module hazard_track_stage
  import forwarding_hazard_unit_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_bubble,
  input  track_entry_t i_entry,
  output track_entry_t o_entry
);

  track_entry_t r_entry;

  // Capture the upstream entry, or an all-zero (invalid) entry on a bubble.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_entry <= '0;
    end else if (i_bubble) begin
      r_entry <= '0;
    end else begin
      r_entry <= i_entry;
    end
  end

  assign o_entry = r_entry;

endmodule

// File: rtl/forwarding_hazard_unit.sv
// Load-use stall detection and EX operand forward-select generation for a
// classic 5-stage pipeline. Tracks the instructions in EX, MEM and WB.
module forwarding_hazard_unit #(
  // Must match the package width, which sizes the tracking record.
  parameter int unsigned REG_ADDR_W = forwarding_hazard_unit_pkg::REG_ADDR_W,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_id_valid,
  input  logic [REG_ADDR_W-1:0] i_id_rs,
  input  logic [REG_ADDR_W-1:0] i_id_rt,
  input  logic                  i_id_uses_rs,
  input  logic                  i_id_uses_rt,
  input  logic                  i_id_reg_write,
  input  logic                  i_id_mem_read,
  input  logic [REG_ADDR_W-1:0] i_id_dest,
  input  logic                  i_flush,
  output logic                  o_stall,
  output logic [1:0]            o_forward_a,
  output logic [1:0]            o_forward_b,
  output logic [CNT_W-1:0]      o_stall_count
);

  import forwarding_hazard_unit_pkg::*;

  track_entry_t w_id_entry;
  track_entry_t w_ex;
  track_entry_t w_mem;
  track_entry_t w_wb;
  logic         w_load_use;
  logic         w_stall;
  logic         w_bubble;
  logic [1:0]   w_fwd_a_d;
  logic [1:0]   w_fwd_b_d;

  logic [1:0]       r_fwd_a;
  logic [1:0]       r_fwd_b;
  logic [CNT_W-1:0] r_stall_count;

  assign w_id_entry = '{valid:     i_id_valid,
                        reg_write: i_id_reg_write,
                        mem_read:  i_id_mem_read,
                        dest:      i_id_dest};

  hazard_track_stage u_ex_stage (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_bubble(w_bubble),
    .i_entry (w_id_entry),
    .o_entry (w_ex)
  );

  hazard_track_stage u_mem_stage (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_bubble(1'b0),
    .i_entry (w_ex),
    .o_entry (w_mem)
  );

  hazard_track_stage u_wb_stage (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_bubble(1'b0),
    .i_entry (w_mem),
    .o_entry (w_wb)
  );

  // WB is tracked only to complete the pipe; the register file bypasses it.
  logic unused_wb;
  assign unused_wb = ^w_wb;

  // Load in EX whose result the ID instruction needs next cycle.
  always_comb begin
    w_load_use = w_ex.valid && w_ex.mem_read && (w_ex.dest != '0) &&
                 ((i_id_uses_rs && (w_ex.dest == i_id_rs)) ||
                  (i_id_uses_rt && (w_ex.dest == i_id_rt)));
  end

  // A flushed instruction is squashed anyway, so it never stalls.
  assign w_stall  = i_id_valid && !i_flush && w_load_use;
  assign w_bubble = w_stall || i_flush || !i_id_valid;
  assign o_stall  = w_stall;

  // Next forward selects: newest producer (EX) wins over MEM.
  always_comb begin
    w_fwd_a_d = FWD_REG;
    w_fwd_b_d = FWD_REG;
    if (!w_bubble) begin
      if (produces(w_ex, i_id_rs, i_id_uses_rs)) begin
        w_fwd_a_d = FWD_EXMEM;
      end else if (produces(w_mem, i_id_rs, i_id_uses_rs)) begin
        w_fwd_a_d = FWD_WB;
      end
      if (produces(w_ex, i_id_rt, i_id_uses_rt)) begin
        w_fwd_b_d = FWD_EXMEM;
      end else if (produces(w_mem, i_id_rt, i_id_uses_rt)) begin
        w_fwd_b_d = FWD_WB;
      end
    end
  end

  // Forward selects move into EX together with the instruction.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fwd_a <= FWD_REG;
      r_fwd_b <= FWD_REG;
    end else begin
      r_fwd_a <= w_fwd_a_d;
      r_fwd_b <= w_fwd_b_d;
    end
  end

  // Saturating count of load-use stall cycles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_count <= '0;
    end else if (w_stall && (r_stall_count != '1)) begin
      r_stall_count <= r_stall_count + CNT_W'(1);
    end
  end

  assign o_forward_a   = r_fwd_a;
  assign o_forward_b   = r_fwd_b;
  assign o_stall_count = r_stall_count;

endmodule
